guess_generator: RTL and testbench

GUESS_GENERATOR -- requirements
Module: guess_generator

---
 rtl/guess_generator.sv | 180 ++++++++++++++++++
 tb/tb_guess_generator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/guess_generator.sv
// guess_generator: odometer-style candidate string generator.
// Walks every string of length L over a selectable charset.
module guess_generator #(
  parameter int MAX_LEN = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             charset,
  input  logic [4:0]             guesslen,
  output logic [8*MAX_LEN-1:0]   guess,
  output logic                   done
);

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    DONE
  } state_t;

  localparam logic [5:0] LMAX = 6'(MAX_LEN);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [2:0]              r_cs;
  logic [2:0]              w_cs;
  logic [5:0]              r_len;
  logic [5:0]              w_len;
  logic [MAX_LEN-1:0][6:0] r_idx;
  logic [MAX_LEN-1:0][6:0] w_idx_nxt;
  logic [8*MAX_LEN-1:0]    r_guess;
  logic [8*MAX_LEN-1:0]    w_guess_nxt;
  logic                    r_done;
  logic                    w_done_nxt;
  logic [6:0]              w_top;
  logic                    w_last;
  logic                    w_carry;
  logic                    w_upd;

  function automatic logic [6:0] f_size(
    input logic [2:0] cs
  );
    case (cs)
      3'd1:    return 7'd26;
      3'd2:    return 7'd10;
      3'd3:    return 7'd36;
      3'd4:    return 7'd52;
      3'd5:    return 7'd62;
      3'd6:    return 7'd95;
      default: return 7'd26;
    endcase
  endfunction

  function automatic logic [7:0] f_char(
    input logic [2:0] cs,
    input logic [6:0] i
  );
    logic [7:0] v;
    v = {1'b0, i};
    case (cs)
      3'd1: return 8'h41 + v;
      3'd2: return 8'h30 + v;
      3'd3: begin
        if (v < 8'd26) return 8'h61 + v;
        return 8'h30 + v - 8'd26;
      end
      3'd4: begin
        if (v < 8'd26) return 8'h61 + v;
        return 8'h41 + v - 8'd26;
      end
      3'd5: begin
        if (v < 8'd26) return 8'h61 + v;
        if (v < 8'd52) return 8'h41 + v - 8'd26;
        return 8'h30 + v - 8'd52;
      end
      3'd6:    return 8'h20 + v;
      default: return 8'h61 + v;
    endcase
  endfunction

  // zero means one character; anything past MAX_LEN clamps
  function automatic logic [5:0] f_len(
    input logic [4:0] gl
  );
    if (gl == 5'd0) return 6'd1;
    if ({1'b0, gl} > LMAX) return LMAX;
    return {1'b0, gl};
  endfunction

  // configuration is taken live in LOAD, frozen afterwards
  always_comb begin
    w_cs  = r_cs;
    w_len = r_len;
    if (r_state == LOAD) begin
      w_cs  = charset;
      w_len = f_len(guesslen);
    end
    w_top = f_size(w_cs) - 7'd1;
  end

  // next state, odometer step and candidate rebuild
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_guess_nxt = r_guess;
    w_done_nxt  = r_done;
    w_last      = 1'b1;
    w_carry     = 1'b1;
    w_upd       = 1'b0;
    for (int p = 0; p < MAX_LEN; p++) begin
      if (6'(p) < r_len && r_idx[p] != w_top)
        w_last = 1'b0;
    end
    unique case (r_state)
      LOAD: begin
        w_idx_nxt   = '0;
        w_upd       = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_upd = 1'b1;
          for (int p = 0; p < MAX_LEN; p++) begin
            if (6'(p) < r_len && w_carry) begin
              if (r_idx[p] == w_top) begin
                w_idx_nxt[p] = 7'd0;
              end else begin
                w_idx_nxt[p] = r_idx[p] + 7'd1;
                w_carry      = 1'b0;
              end
            end
          end
        end
      end
      DONE: begin
        w_state_nxt = DONE;
      end
      default: begin
        w_state_nxt = LOAD;
      end
    endcase
    if (w_upd) begin
      for (int p = 0; p < MAX_LEN; p++) begin
        if (6'(p) < w_len)
          w_guess_nxt[8*p +: 8] = f_char(w_cs, w_idx_nxt[p]);
        else
          w_guess_nxt[8*p +: 8] = 8'h00;
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= LOAD;
    else        r_state <= w_state_nxt;
  end

  // datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cs    <= 3'd0;
      r_len   <= 6'd1;
      r_idx   <= '0;
      r_guess <= '0;
      r_done  <= 1'b0;
    end else begin
      r_cs    <= w_cs;
      r_len   <= w_len;
      r_idx   <= w_idx_nxt;
      r_guess <= w_guess_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign guess = r_guess;
  assign done  = r_done;

endmodule

// File: tb/tb_guess_generator.sv
// tb_guess_generator: directed vectors for guess_generator.
// Expected strings are hand-computed ASCII.
module tb_guess_generator;

  logic         clk;
  logic         reset;
  logic [2:0]   charset;
  logic [4:0]   guesslen;
  logic [127:0] guess;
  logic         done;

  int n_vec;
  int n_bad;

  guess_generator #(.MAX_LEN(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .charset  (charset),
    .guesslen (guesslen),
    .guess    (guess),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(
    input logic [2:0] cs,
    input logic [4:0] gl
  );
    @(negedge clk);
    reset    = 1'b0;
    charset  = cs;
    guesslen = gl;
    #2;
    chk("rst_guess", guess, 128'h0);
    chk("rst_done", {127'b0, done}, 128'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    reset    = 1'b0;
    charset  = 3'd0;
    guesslen = 5'd0;
    #13;
    chk("por_guess", guess, 128'h0);
    chk("por_done", {127'b0, done}, 128'h0);

    // digits, length 1
    start(3'd2, 5'd1);
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("dig_guess", guess, 128'(8'h30 + 8'(k)));
      chk("dig_done", {127'b0, done}, 128'h0);
    end
    step(1);
    chk("dig_end_done", {127'b0, done}, 128'h1);
    chk("dig_end_guess", guess, 128'h39);
    step(3);
    chk("dig_hold_done", {127'b0, done}, 128'h1);
    chk("dig_hold_guess", guess, 128'h39);

    // lowercase, length 2 (reset from DONE)
    start(3'd0, 5'd2);
    step(1);
    chk("lc_e1", guess, 128'h6161);
    step(1);
    chk("lc_e2", guess, 128'h6162);
    step(25);
    chk("lc_e27", guess, 128'h6261);
    step(649);
    chk("lc_e676", guess, 128'h7A7A);
    chk("lc_e676_done", {127'b0, done}, 128'h0);
    step(1);
    chk("lc_e677_done", {127'b0, done}, 128'h1);
    chk("lc_e677_guess", guess, 128'h7A7A);

    // printable, length 1
    start(3'd6, 5'd1);
    step(1);
    chk("pr_e1", guess, 128'h20);
    begin
      int seen;
      seen = 0;
      for (int k = 2; k <= 95; k++) begin
        step(1);
        if (done) seen++;
      end
      chk("pr_no_early_done", 128'(seen), 128'h0);
    end
    chk("pr_e95", guess, 128'h7E);
    step(1);
    chk("pr_e96_done", {127'b0, done}, 128'h1);

    // length clamp above MAX_LEN
    start(3'd2, 5'd20);
    step(1);
    chk("clamp20", guess, {16{8'h30}});

    // length 0 acts as 1
    start(3'd0, 5'd0);
    step(1);
    chk("len0_e1", guess, 128'h61);
    step(25);
    chk("len0_e26", guess, 128'h7A);
    step(1);
    chk("len0_done", {127'b0, done}, 128'h1);

    // full alnum set, length 3
    start(3'd5, 5'd3);
    step(1);
    chk("an_e1", guess, 128'h616161);
    step(1);
    chk("an_e2", guess, 128'h616162);
    step(25);
    chk("an_e27", guess, 128'h616141);
    step(26);
    chk("an_e53", guess, 128'h616130);
    step(10);
    chk("an_e63", guess, 128'h616261);

    // lowercase+digits, length 1
    start(3'd3, 5'd1);
    step(27);
    chk("ld_e27", guess, 128'h30);
    step(9);
    chk("ld_e36", guess, 128'h39);
    step(1);
    chk("ld_done", {127'b0, done}, 128'h1);

    // lower+upper, length 1
    start(3'd4, 5'd1);
    step(52);
    chk("lu_e52", guess, 128'h5A);
    chk("lu_e52_done", {127'b0, done}, 128'h0);

    // uppercase and select 7
    start(3'd1, 5'd1);
    step(1);
    chk("uc_e1", guess, 128'h41);
    start(3'd7, 5'd1);
    step(1);
    chk("cs7_e1", guess, 128'h61);
    step(26);
    chk("cs7_done", {127'b0, done}, 128'h1);

    // mid-run async reset then reconfigure
    start(3'd0, 5'd2);
    step(30);
    chk("mid_e30", guess, 128'h6264);
    reset = 1'b0;
    #1;
    chk("mid_rst_guess", guess, 128'h0);
    chk("mid_rst_done", {127'b0, done}, 128'h0);
    charset = 3'd2;
    @(negedge clk);
    reset = 1'b1;
    step(1);
    chk("mid_e1", guess, 128'h3030);
    charset  = 3'd0;
    guesslen = 5'd1;
    step(1);
    chk("mid_frozen", guess, 128'h3031);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
